pia_kbd_fifo: RTL and testbench



---
 rtl/pia_kbd_fifo.sv | 132 +++++++++++++
 tb/tb_pia_kbd_fifo.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pia_kbd_fifo.sv
// Apple-1 PIA keyboard port with a DEPTH-entry type-ahead FIFO behind the KBD/KBDCR registers.
// Optional build macro KBD_UPCASE_EN folds 'a'..'z' to 'A'..'Z' on capture.
module pia_kbd_fifo #(
  parameter int          DATA_W     = 7,
  parameter int          DEPTH      = 8,
  parameter logic [15:0] KBD_ADDR   = 16'hD010,
  parameter logic [15:0] KBDCR_ADDR = 16'hD011
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [15:0]             Address_Bus,
  input  logic                    WE,
  output logic [DATA_W:0]         Data_Out,
  input  logic                    kbd_rdy,
  output logic                    kbd_ack,
  input  logic [DATA_W-1:0]       kbd_data,
  output logic [$clog2(DEPTH):0]  fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Keyboard side handshake: kbd_rdy is the request, kbd_ack the registered reply.
  // A character is captured only when kbd_rdy=1 in S_IDLE with room in the FIFO;
  // kbd_ack then stays high until kbd_rdy falls, followed by one forced ack-low cycle.
  typedef enum logic [2:0] {
    S_IDLE = 3'b001,
    S_ACK  = 3'b010,
    S_REL  = 3'b100
  } kbd_state_t;

  kbd_state_t        state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [DATA_W-1:0] hold;
  logic              prev_rd;
  logic              rd_kbd;
  logic              rd_kbdcr;
  logic              not_empty;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] push_data;

  assign not_empty = (fifo_count != '0);
  assign rd_kbd    = (Address_Bus == KBD_ADDR) && !WE;
  assign rd_kbdcr  = (Address_Bus == KBDCR_ADDR) && !WE;
  // A held read address pops once: only the first cycle of the access counts.
  assign pop       = rd_kbd && !prev_rd && not_empty;
  assign push      = (state == S_IDLE) && kbd_rdy && (fifo_count < CW'(DEPTH));

  always_comb begin
    push_data = kbd_data;
`ifdef KBD_UPCASE_EN
    if (kbd_data[6:0] >= 7'h61 && kbd_data[6:0] <= 7'h7A)
      push_data[5] = 1'b0;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      kbd_ack <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (push) begin
            kbd_ack <= 1'b1;
            state   <= S_ACK;
          end else begin
            kbd_ack <= 1'b0;
          end
        end
        S_ACK: begin
          if (!kbd_rdy) begin
            kbd_ack <= 1'b0;
            state   <= S_REL;
          end else begin
            kbd_ack <= 1'b1;
          end
        end
        S_REL: begin
          kbd_ack <= 1'b0;
          state   <= S_IDLE;
        end
        default: begin
          kbd_ack <= 1'b0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      hold       <= '0;
      prev_rd    <= 1'b0;
    end else begin
      prev_rd <= rd_kbd;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        hold   <= mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Storage needs no reset: an entry is only ever read after it has been written.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // After the popping cycle the bus sees the consumed byte with bit 7 cleared.
  always_comb begin
    Data_Out = '0;
    if (rd_kbd && !prev_rd)
      Data_Out = not_empty ? {1'b1, mem[rd_ptr]} : '0;
    else if (rd_kbd)
      Data_Out = {1'b0, hold};
    else if (rd_kbdcr)
      Data_Out = {not_empty, {DATA_W{1'b0}}};
  end

endmodule

// File: tb/tb_pia_kbd_fifo.sv
// Self-checking bench for pia_kbd_fifo: directed scenarios plus random traffic
// against a queue model of the type-ahead buffer.
module tb_pia_kbd_fifo;

  localparam logic [15:0] KBD   = 16'hD010;
  localparam logic [15:0] KBDCR = 16'hD011;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] Address_Bus = 16'h0000;
  logic        WE = 1'b0;
  logic [7:0]  Data_Out;
  logic        kbd_rdy = 1'b0;
  logic        kbd_ack;
  logic [6:0]  kbd_data = 7'h00;
  logic [3:0]  fifo_count;

  int n_checks = 0;
  int n_pass   = 0;

  logic [6:0] exp_q[$];
  logic [6:0] exp_hold = 7'h00;

  pia_kbd_fifo dut (
    .clk(clk), .reset(reset), .Address_Bus(Address_Bus), .WE(WE),
    .Data_Out(Data_Out), .kbd_rdy(kbd_rdy), .kbd_ack(kbd_ack),
    .kbd_data(kbd_data), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [6:0] stored(input logic [6:0] c);
`ifdef KBD_UPCASE_EN
    if (c >= 7'h61 && c <= 7'h7A) return c - 7'd32;
`endif
    return c;
  endfunction

  // Bounded wait for kbd_ack to reach lvl; returns at a falling edge.
  task automatic wait_ack(input logic lvl, input string tag);
    int i = 0;
    do begin @(negedge clk); i++; end while (kbd_ack !== lvl && i < 20);
    n_checks++;
    if (kbd_ack !== lvl) $display("FAIL %s: kbd_ack=%b required %b", tag, kbd_ack, lvl);
    else n_pass++;
  endtask

  // Full four-phase handshake for one character, including the release cycle.
  task automatic send_char(input logic [6:0] c);
    kbd_data = c;
    kbd_rdy  = 1'b1;
    wait_ack(1'b1, "send_ack_high");
    kbd_rdy = 1'b0;
    exp_q.push_back(stored(c));
    n_checks++;
    if (fifo_count !== 4'(exp_q.size()))
      $display("FAIL send_count: fifo_count=%0d required %0d", fifo_count, exp_q.size());
    else n_pass++;
    wait_ack(1'b0, "send_ack_low");
    @(negedge clk);
  endtask

  // KBD read held for n cycles, then one idle bus cycle.
  task automatic read_kbd(input int n);
    logic [7:0] exp_first;
    Address_Bus = KBD;
    WE = 1'b0;
    exp_first = (exp_q.size() != 0) ? {1'b1, exp_q[0]} : 8'h00;
    #1;
    n_checks++;
    if (Data_Out !== exp_first)
      $display("FAIL read_first: Data_Out=%h required %h", Data_Out, exp_first);
    else n_pass++;
    if (exp_q.size() != 0) exp_hold = exp_q.pop_front();
    for (int k = 1; k < n; k++) begin
      @(negedge clk); #1;
      n_checks++;
      if (Data_Out !== {1'b0, exp_hold})
        $display("FAIL read_hold: Data_Out=%h required %h", Data_Out, {1'b0, exp_hold});
      else n_pass++;
    end
    @(negedge clk);
    Address_Bus = 16'h0000;
    @(negedge clk);
    n_checks++;
    if (fifo_count !== 4'(exp_q.size()))
      $display("FAIL read_count: fifo_count=%0d required %0d", fifo_count, exp_q.size());
    else n_pass++;
  endtask

  task automatic test_reset;
    Address_Bus = KBDCR;
    #1;
    n_checks++;
    if (Data_Out !== 8'h00 || kbd_ack !== 1'b0 || fifo_count !== 4'd0)
      $display("FAIL reset_state: Data_Out=%h ack=%b count=%0d required 00/0/0", Data_Out, kbd_ack, fifo_count);
    else n_pass++;
    Address_Bus = 16'h0000;
    @(negedge clk);
  endtask

  task automatic test_handshake;
    kbd_data = 7'h41;
    kbd_rdy  = 1'b1;
    @(negedge clk);
    n_checks++;
    if (kbd_ack !== 1'b1 || fifo_count !== 4'd1)
      $display("FAIL hs_capture: ack=%b count=%0d required 1/1", kbd_ack, fifo_count);
    else n_pass++;
    kbd_rdy = 1'b0;
    @(negedge clk);
    n_checks++;
    if (kbd_ack !== 1'b0) $display("FAIL hs_release: ack=%b required 0", kbd_ack);
    else n_pass++;
    @(negedge clk);
    exp_q.push_back(7'h41);
    Address_Bus = KBDCR;
    #1;
    n_checks++;
    if (Data_Out !== 8'h80) $display("FAIL hs_kbdcr: Data_Out=%h required 80", Data_Out);
    else n_pass++;
    @(negedge clk);
    Address_Bus = 16'h0000;
    @(negedge clk);
    read_kbd(3);
  endtask

  task automatic test_full_wrap;
    for (int c = 8'h30; c <= 8'h37; c++) send_char(7'(c));
    kbd_data = 7'h38;
    kbd_rdy  = 1'b1;
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if (kbd_ack !== 1'b0 || fifo_count !== 4'd8)
        $display("FAIL full_backpressure: ack=%b count=%0d required 0/8", kbd_ack, fifo_count);
      else n_pass++;
    end
    Address_Bus = KBD;
    #1;
    n_checks++;
    if (Data_Out !== 8'hB0) $display("FAIL full_pop_head: Data_Out=%h required B0", Data_Out);
    else n_pass++;
    @(negedge clk); #1;
    n_checks++;
    if (fifo_count !== 4'd7 || kbd_ack !== 1'b0 || Data_Out !== 8'h30)
      $display("FAIL full_after_pop: count=%0d ack=%b Data_Out=%h required 7/0/30", fifo_count, kbd_ack, Data_Out);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (fifo_count !== 4'd8 || kbd_ack !== 1'b1)
      $display("FAIL full_late_push: count=%0d ack=%b required 8/1", fifo_count, kbd_ack);
    else n_pass++;
    Address_Bus = 16'h0000;
    kbd_rdy = 1'b0;
    exp_hold = exp_q.pop_front();
    exp_q.push_back(7'h38);
    wait_ack(1'b0, "full_ack_low");
    @(negedge clk);
    for (int i = 0; i < 8; i++) read_kbd(2);
  endtask

  task automatic test_empty_read;
    read_kbd(1);
    read_kbd(2);
  endtask

  task automatic test_push_pop_same;
    send_char(7'h45);
    kbd_data = 7'h5A;
    kbd_rdy = 1'b1;
    Address_Bus = KBD;
    #1;
    n_checks++;
    if (Data_Out !== 8'hC5) $display("FAIL pp1_head: Data_Out=%h required C5", Data_Out);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (fifo_count !== 4'd1 || kbd_ack !== 1'b1)
      $display("FAIL pp1_count: count=%0d ack=%b required 1/1", fifo_count, kbd_ack);
    else n_pass++;
    exp_hold = exp_q.pop_front();
    exp_q.push_back(7'h5A);
    Address_Bus = 16'h0000;
    kbd_rdy = 1'b0;
    wait_ack(1'b0, "pp1_ack_low");
    @(negedge clk);
    read_kbd(1);
    // Empty FIFO: the push lands but the read sees nothing and pops nothing.
    kbd_data = 7'h2A;
    kbd_rdy = 1'b1;
    Address_Bus = KBD;
    #1;
    n_checks++;
    if (Data_Out !== 8'h00) $display("FAIL pp0_head: Data_Out=%h required 00", Data_Out);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (fifo_count !== 4'd1 || kbd_ack !== 1'b1)
      $display("FAIL pp0_count: count=%0d ack=%b required 1/1", fifo_count, kbd_ack);
    else n_pass++;
    exp_q.push_back(7'h2A);
    Address_Bus = 16'h0000;
    kbd_rdy = 1'b0;
    wait_ack(1'b0, "pp0_ack_low");
    @(negedge clk);
    read_kbd(1);
  endtask

  task automatic test_upcase;
    send_char(7'h71);
    send_char(7'h60);
    send_char(7'h61);
    send_char(7'h7A);
    send_char(7'h7B);
    repeat (5) read_kbd(1);
  endtask

  task automatic test_random;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 1) == 1 && exp_q.size() < 8)
        send_char(7'($urandom_range(0, 127)));
      else
        read_kbd(int'($urandom_range(1, 3)));
    end
    while (exp_q.size() != 0) read_kbd(1);
  endtask

  task automatic test_reset_mid;
    send_char(7'h11);
    kbd_data = 7'h55;
    kbd_rdy = 1'b1;
    @(negedge clk);
    n_checks++;
    if (kbd_ack !== 1'b1) $display("FAIL rst_pre_ack: ack=%b required 1", kbd_ack);
    else n_pass++;
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (kbd_ack !== 1'b0 || fifo_count !== 4'd0)
      $display("FAIL rst_async: ack=%b count=%0d required 0/0", kbd_ack, fifo_count);
    else n_pass++;
    exp_q.delete();
    exp_hold = 7'h00;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (kbd_ack !== 1'b1 || fifo_count !== 4'd1)
      $display("FAIL rst_recapture: ack=%b count=%0d required 1/1", kbd_ack, fifo_count);
    else n_pass++;
    exp_q.push_back(stored(7'h55));
    kbd_rdy = 1'b0;
    wait_ack(1'b0, "rst_ack_low");
    @(negedge clk);
    read_kbd(2);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    test_reset();
    test_handshake();
    test_full_wrap();
    test_empty_read();
    test_push_pop_same();
    test_upcase();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
